// File: rtl/load_extend_unit_pkg.sv
// Shared load-formatting definitions: MIPS load opcodes and lane-kind decode.
// Optional feature macro: LOAD_EXTEND_LWLR_EN (LWL/LWR unaligned merge).
package load_extend_unit_pkg;

  localparam logic [5:0] OPCODE_LB  = 6'h20;
  localparam logic [5:0] OPCODE_LH  = 6'h21;
  localparam logic [5:0] OPCODE_LWL = 6'h22;
  localparam logic [5:0] OPCODE_LW  = 6'h23;
  localparam logic [5:0] OPCODE_LBU = 6'h24;
  localparam logic [5:0] OPCODE_LHU = 6'h25;
  localparam logic [5:0] OPCODE_LWR = 6'h26;

  typedef enum logic [2:0] {
    BYTE,
    HALF,
    WORD,
    LEFT,
    RIGHT
  } load_kind_t;

  // Unknown opcodes (and LWL/LWR when the merge is not built) behave as WORD.
  function automatic load_kind_t decode_kind(input logic [5:0] opcode);
    load_kind_t k;
    case (opcode)
      OPCODE_LB, OPCODE_LBU: k = BYTE;
      OPCODE_LH, OPCODE_LHU: k = HALF;
`ifdef LOAD_EXTEND_LWLR_EN
      OPCODE_LWL:            k = LEFT;
      OPCODE_LWR:            k = RIGHT;
`endif
      default:               k = WORD;
    endcase
    return k;
  endfunction

  function automatic logic is_unsigned(input logic [5:0] opcode);
    return (opcode == OPCODE_LBU) || (opcode == OPCODE_LHU);
  endfunction

endpackage

// File: rtl/load_format.sv
// Combinational lane select and sign/zero extension for one load.
// Optional feature macro: LOAD_EXTEND_LWLR_EN adds the rt_data port and LWL/LWR merge.
module load_format
  import load_extend_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int OFS_W = $clog2(DATA_WIDTH / 8)
) (
  input  logic [5:0]            opcode,
  input  logic [OFS_W-1:0]      offset,
  input  logic [DATA_WIDTH-1:0] mem_data,
`ifdef LOAD_EXTEND_LWLR_EN
  input  logic [DATA_WIDTH-1:0] rt_data,
`endif
  output logic [DATA_WIDTH-1:0] data,
  output logic                  addr_err
);

  load_kind_t            kind;
  logic                  uns;
  logic [OFS_W-1:0]      ofs_h;
  logic [DATA_WIDTH-1:0] byte_sh;
  logic [DATA_WIDTH-1:0] half_sh;
  logic [7:0]            bsel;
  logic [15:0]           hsel;
`ifdef LOAD_EXTEND_LWLR_EN
  logic [DATA_WIDTH-1:0] lmask;
  logic [DATA_WIDTH-1:0] rmask;
`endif

  // Pick the addressed lane and extend it; misaligned halves use the even lane.
  always_comb begin
    kind     = decode_kind(opcode);
    uns      = is_unsigned(opcode);
    ofs_h    = offset;
    ofs_h[0] = 1'b0;
    byte_sh  = mem_data >> {offset, 3'b000};
    half_sh  = mem_data >> {ofs_h, 3'b000};
    bsel     = byte_sh[7:0];
    hsel     = half_sh[15:0];
`ifdef LOAD_EXTEND_LWLR_EN
    // ~offset*8 == DATA_WIDTH-8*(offset+1) because lanes are a power of two.
    lmask    = '1;
    lmask    = lmask << {~offset, 3'b000};
    rmask    = '1;
    rmask    = rmask >> {offset, 3'b000};
`endif
    data     = mem_data;
    addr_err = 1'b0;
    case (kind)
      BYTE: data = {{(DATA_WIDTH-8){bsel[7] & ~uns}}, bsel};
      HALF: begin
        data     = {{(DATA_WIDTH-16){hsel[15] & ~uns}}, hsel};
        addr_err = offset[0];
      end
`ifdef LOAD_EXTEND_LWLR_EN
      LEFT:  data = (mem_data << {~offset, 3'b000}) | (rt_data & ~lmask);
      RIGHT: data = (mem_data >> {offset, 3'b000}) | (rt_data & ~rmask);
`endif
      default: addr_err = (opcode == OPCODE_LW) && (offset != '0);
    endcase
  end

endmodule

// File: rtl/load_extend_unit.sv
// Registered load-data formatter with valid/ready and a two-entry skid.
// Optional feature macro: LOAD_EXTEND_LWLR_EN (LWL/LWR merge using in_rt_data).
module load_extend_unit
  import load_extend_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int OFS_W = $clog2(DATA_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            in_opcode,
  input  logic [OFS_W-1:0]      in_offset,
  input  logic [DATA_WIDTH-1:0] in_mem_data,
  input  logic [DATA_WIDTH-1:0] in_rt_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_addr_err
);

  logic [DATA_WIDTH-1:0] fmt_data;
  logic                  fmt_err;

  logic                  main_valid;
  logic [DATA_WIDTH-1:0] main_data;
  logic                  main_err;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_err;

  load_format #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_format (
    .opcode   (in_opcode),
    .offset   (in_offset),
    .mem_data (in_mem_data),
`ifdef LOAD_EXTEND_LWLR_EN
    .rt_data  (in_rt_data),
`endif
    .data     (fmt_data),
    .addr_err (fmt_err)
  );

`ifndef LOAD_EXTEND_LWLR_EN
  logic unused_rt;
  assign unused_rt = ^in_rt_data;
`endif

  // Formatting happens before storage, so rt_data lives inside the stored result.
  assign in_ready     = !skid_valid;
  assign out_valid    = main_valid;
  assign out_data     = main_data;
  assign out_addr_err = main_err;

  // Main/skid pipeline: main refills from skid first, else from the input.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_err   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
    end else if (!main_valid || out_ready) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_err   <= skid_err;
        skid_valid <= 1'b0;
      end else if (in_valid) begin
        main_valid <= 1'b1;
        main_data  <= fmt_data;
        main_err   <= fmt_err;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= fmt_data;
      skid_err   <= fmt_err;
    end
  end

endmodule

// File: tb/tb_load_extend_unit.sv
// Self-checking bench for load_extend_unit (DATA_WIDTH=32), scoreboard based.
// Honours LOAD_EXTEND_LWLR_EN for the expected LWL/LWR results.
module tb_load_extend_unit;
  import load_extend_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [1:0]  in_offset;
  logic [31:0] in_mem_data;
  logic [31:0] in_rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_addr_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [32:0] expq[$];

  typedef struct packed {
    logic [5:0]  op;
    logic [1:0]  ofs;
    logic [31:0] mem;
    logic [31:0] rt;
    logic [32:0] exp;
  } vec_t;

  load_extend_unit #(
    .DATA_WIDTH(32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_offset    (in_offset),
    .in_mem_data  (in_mem_data),
    .in_rt_data   (in_rt_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_addr_err (out_addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {addr_err, data}.
  function automatic logic [32:0] model(input logic [5:0] op, input logic [1:0] ofs,
                                        input logic [31:0] mem, input logic [31:0] rt);
    logic [7:0]  b [4];
    logic [15:0] h;
    logic [31:0] d;
    logic        e;
    logic        unused_rt;
    unused_rt = ^rt;
    for (int i = 0; i < 4; i++) b[i] = mem[8*i +: 8];
    h = {b[{ofs[1], 1'b1}], b[{ofs[1], 1'b0}]};
    d = mem;
    e = 1'b0;
    case (op)
      OPCODE_LB:  d = {{24{b[ofs][7]}}, b[ofs]};
      OPCODE_LBU: d = {24'h0, b[ofs]};
      OPCODE_LH:  begin d = {{16{h[15]}}, h}; e = ofs[0]; end
      OPCODE_LHU: begin d = {16'h0, h}; e = ofs[0]; end
      OPCODE_LW:  e = (ofs != 2'd0);
`ifdef LOAD_EXTEND_LWLR_EN
      OPCODE_LWL: case (ofs)
        2'd0:    d = {mem[7:0], rt[23:0]};
        2'd1:    d = {mem[15:0], rt[15:0]};
        2'd2:    d = {mem[23:0], rt[7:0]};
        default: d = mem;
      endcase
      OPCODE_LWR: case (ofs)
        2'd0:    d = mem;
        2'd1:    d = {rt[31:24], mem[31:8]};
        2'd2:    d = {rt[31:16], mem[31:16]};
        default: d = {rt[31:8], mem[31:24]};
      endcase
`endif
      default: ;
    endcase
    return {e, d};
  endfunction

  // One clock: drive at the falling edge, sample 1 time unit later, push on accept.
  task automatic tick(input logic v, input logic [5:0] op, input logic [1:0] ofs,
                      input logic [31:0] mem, input logic [31:0] rt, input logic [32:0] exp,
                      input logic rdy, output logic acc, output logic ov,
                      output logic xfer, output logic [32:0] obs);
    in_valid    = v;
    in_opcode   = op;
    in_offset   = ofs;
    in_mem_data = mem;
    in_rt_data  = rt;
    out_ready   = rdy;
    #1;
    acc  = v && in_ready;
    ov   = out_valid;
    xfer = out_valid && rdy;
    obs  = {out_addr_err, out_data};
    if (acc) expq.push_back(exp);
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic acc, ov, xfer;
    logic [32:0] obs;
    reset = 1'b1;
    tick(1'b0, 6'h0, 2'd0, 32'h0, 32'h0, 33'h0, 1'b0, acc, ov, xfer, obs);
    tick(1'b0, 6'h0, 2'd0, 32'h0, 32'h0, 33'h0, 1'b0, acc, ov, xfer, obs);
    reset = 1'b0;
    tick(1'b0, 6'h0, 2'd0, 32'h0, 32'h0, 33'h0, 1'b0, acc, ov, xfer, obs);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h, expected 00000000", out_data); end
    checks++;
    if (out_addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b, expected 0", out_addr_err); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_format;
    vec_t vt[15];
    logic acc, ov, xfer;
    logic [32:0] obs, exp;
    vt[0]  = '{OPCODE_LB,  2'd2, 32'h1280_3456, 32'h0, 33'h0_FFFF_FF80};
    vt[1]  = '{OPCODE_LBU, 2'd2, 32'h1280_3456, 32'h0, 33'h0_0000_0080};
    vt[2]  = '{OPCODE_LHU, 2'd2, 32'h8001_0000, 32'h0, 33'h0_0000_8001};
    vt[3]  = '{OPCODE_LH,  2'd1, 32'h8001_0000, 32'h0, 33'h1_0000_0000};
    vt[4]  = '{OPCODE_LW,  2'd2, 32'hDEAD_BEEF, 32'h0, 33'h1_DEAD_BEEF};
    vt[5]  = '{OPCODE_LW,  2'd0, 32'hDEAD_BEEF, 32'h0, 33'h0_DEAD_BEEF};
    vt[6]  = '{OPCODE_LB,  2'd3, 32'h1280_3456, 32'h0, 33'h0_0000_0012};
    vt[7]  = '{OPCODE_LH,  2'd3, 32'h8001_0000, 32'h0, 33'h1_FFFF_8001};
    vt[8]  = '{OPCODE_LHU, 2'd0, 32'h1234_FEDC, 32'h0, 33'h0_0000_FEDC};
    vt[9]  = '{OPCODE_LB,  2'd0, 32'h0000_00FF, 32'h0, 33'h0_FFFF_FFFF};
    vt[10] = '{6'h3F,      2'd1, 32'hCAFE_F00D, 32'h0, 33'h0_CAFE_F00D};
`ifdef LOAD_EXTEND_LWLR_EN
    vt[11] = '{OPCODE_LWL, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 33'h0_CCDD_3344};
    vt[12] = '{OPCODE_LWR, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 33'h0_11AA_BBCC};
    vt[13] = '{OPCODE_LWL, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 33'h0_DD22_3344};
    vt[14] = '{OPCODE_LWR, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 33'h0_1122_33AA};
`else
    vt[11] = '{OPCODE_LWL, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 33'h0_AABB_CCDD};
    vt[12] = '{OPCODE_LWR, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 33'h0_AABB_CCDD};
    vt[13] = '{OPCODE_LWL, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 33'h0_AABB_CCDD};
    vt[14] = '{OPCODE_LWR, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 33'h0_AABB_CCDD};
`endif
    for (int i = 0; i < 15; i++) begin
      tick(1'b1, vt[i].op, vt[i].ofs, vt[i].mem, vt[i].rt, vt[i].exp, 1'b1, acc, ov, xfer, obs);
      if (i == 0) begin
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL latency: out_valid got %b, expected 1", out_valid); end
      end
      if (xfer) begin
        checks++;
        if (expq.size() == 0) begin errors++; $display("FAIL format_extra: got %h, expected no output", obs); end
        else begin
          exp = expq.pop_front();
          if (obs !== exp) begin errors++; $display("FAIL format_%0d: got %h, expected %h", i - 1, obs, exp); end
        end
      end
    end
    for (int i = 0; i < 20 && expq.size() > 0; i++) begin
      tick(1'b0, 6'h0, 2'd0, 32'h0, 32'h0, 33'h0, 1'b1, acc, ov, xfer, obs);
      if (xfer) begin
        checks++;
        exp = expq.pop_front();
        if (obs !== exp) begin errors++; $display("FAIL format_drain: got %h, expected %h", obs, exp); end
      end
    end
    checks++;
    if (expq.size() != 0) begin errors++; $display("FAIL format_timeout: %0d pending, expected 0", expq.size()); expq.delete(); end
  endtask

  task automatic test_back_to_back;
    logic acc, ov, xfer;
    logic [32:0] obs, exp;
    int unsigned nout = 0;
    logic done = 1'b0;
    tick(1'b1, OPCODE_LBU, 2'd0, 32'h0000_0011, 32'h0, 33'h0_0000_0011, 1'b0, acc, ov, xfer, obs);
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL b2b_acc1: got %b, expected 1", acc); end
    tick(1'b1, OPCODE_LBU, 2'd1, 32'h0000_2200, 32'h0, 33'h0_0000_0022, 1'b0, acc, ov, xfer, obs);
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL b2b_acc2: got %b, expected 1", acc); end
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready: got %b, expected 0", in_ready); end
    tick(1'b1, OPCODE_LBU, 2'd2, 32'h0033_0000, 32'h0, 33'h0_0000_0033, 1'b0, acc, ov, xfer, obs);
    checks++;
    if (acc !== 1'b0) begin errors++; $display("FAIL b2b_acc3_blocked: got %b, expected 0", acc); end
    checks++;
    if (obs !== 33'h0_0000_0011) begin errors++; $display("FAIL b2b_hold: got %h, expected 000000011", obs); end
    for (int i = 0; i < 20 && (!done || expq.size() > 0); i++) begin
      tick(!done, OPCODE_LBU, 2'd2, 32'h0033_0000, 32'h0, 33'h0_0000_0033, 1'b1, acc, ov, xfer, obs);
      if (acc) done = 1'b1;
      if (xfer) begin
        nout++;
        checks++;
        if (expq.size() == 0) begin errors++; $display("FAIL b2b_extra: got %h, expected no output", obs); end
        else begin
          exp = expq.pop_front();
          if (obs !== exp) begin errors++; $display("FAIL b2b_order: got %h, expected %h", obs, exp); end
        end
      end
    end
    checks++;
    if (nout != 3) begin errors++; $display("FAIL b2b_count: got %0d, expected 3", nout); expq.delete(); end
  endtask

  task automatic test_no_bubble;
    logic acc, ov, xfer;
    logic [32:0] obs, exp;
    logic [31:0] m;
    for (int i = 0; i < 6; i++) begin
      m = $urandom;
      tick(1'b1, OPCODE_LW, 2'd0, m, 32'h0, model(OPCODE_LW, 2'd0, m, 32'h0), 1'b1, acc, ov, xfer, obs);
      checks++;
      if (acc !== 1'b1) begin errors++; $display("FAIL nobubble_acc_%0d: got %b, expected 1", i, acc); end
      if (i > 0) begin
        checks++;
        if (ov !== 1'b1) begin errors++; $display("FAIL nobubble_valid_%0d: got %b, expected 1", i, ov); end
      end
      if (xfer && expq.size() > 0) begin
        checks++;
        exp = expq.pop_front();
        if (obs !== exp) begin errors++; $display("FAIL nobubble_data: got %h, expected %h", obs, exp); end
      end
    end
    for (int i = 0; i < 10 && expq.size() > 0; i++) begin
      tick(1'b0, 6'h0, 2'd0, 32'h0, 32'h0, 33'h0, 1'b1, acc, ov, xfer, obs);
      if (xfer) begin
        checks++;
        exp = expq.pop_front();
        if (obs !== exp) begin errors++; $display("FAIL nobubble_drain: got %h, expected %h", obs, exp); end
      end
    end
    checks++;
    if (expq.size() != 0) begin errors++; $display("FAIL nobubble_timeout: %0d pending, expected 0", expq.size()); expq.delete(); end
  endtask

  task automatic test_random;
    logic [5:0] ops [10];
    logic acc, ov, xfer, v, rdy;
    logic [32:0] obs, exp, held_obs;
    logic held = 1'b0;
    logic [5:0]  op;
    logic [1:0]  ofs;
    logic [31:0] m, r;
    ops = '{OPCODE_LB, OPCODE_LBU, OPCODE_LH, OPCODE_LHU, OPCODE_LW,
            OPCODE_LWL, OPCODE_LWR, 6'h00, 6'h3F, 6'h27};
    held_obs = '0;
    for (int i = 0; i < 300; i++) begin
      v   = (i < 260) && ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 6);
      op  = ops[$urandom_range(0, 9)];
      ofs = 2'($urandom_range(0, 3));
      m   = $urandom;
      r   = $urandom;
      tick(v, op, ofs, m, r, model(op, ofs, m, r), rdy, acc, ov, xfer, obs);
      if (held) begin
        checks++;
        if (ov !== 1'b1 || obs !== held_obs) begin
          errors++; $display("FAIL rand_stable: got %b/%h, expected 1/%h", ov, obs, held_obs);
        end
      end
      held     = ov && !rdy;
      held_obs = obs;
      if (xfer) begin
        checks++;
        if (expq.size() == 0) begin errors++; $display("FAIL rand_extra: got %h, expected no output", obs); end
        else begin
          exp = expq.pop_front();
          if (obs !== exp) begin errors++; $display("FAIL rand_data: got %h, expected %h", obs, exp); end
        end
      end
    end
    for (int i = 0; i < 10 && expq.size() > 0; i++) begin
      tick(1'b0, 6'h0, 2'd0, 32'h0, 32'h0, 33'h0, 1'b1, acc, ov, xfer, obs);
      if (xfer) begin
        checks++;
        exp = expq.pop_front();
        if (obs !== exp) begin errors++; $display("FAIL rand_drain: got %h, expected %h", obs, exp); end
      end
    end
    checks++;
    if (expq.size() != 0) begin errors++; $display("FAIL rand_timeout: %0d pending, expected 0", expq.size()); expq.delete(); end
  endtask

  task automatic test_reset_mid;
    logic acc, ov, xfer;
    logic [32:0] obs, exp;
    tick(1'b1, OPCODE_LW, 2'd0, 32'h1111_1111, 32'h0, 33'h0_1111_1111, 1'b0, acc, ov, xfer, obs);
    tick(1'b1, OPCODE_LW, 2'd0, 32'h2222_2222, 32'h0, 33'h0_2222_2222, 1'b0, acc, ov, xfer, obs);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_full: in_ready got %b, expected 0", in_ready); end
    reset = 1'b1;
    tick(1'b0, 6'h0, 2'd0, 32'h0, 32'h0, 33'h0, 1'b0, acc, ov, xfer, obs);
    reset = 1'b0;
    expq.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b, expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b, expected 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 6'h0, 2'd0, 32'h0, 32'h0, 33'h0, 1'b1, acc, ov, xfer, obs);
      checks++;
      if (ov !== 1'b0) begin errors++; $display("FAIL rstmid_pulse_%0d: out_valid got %b, expected 0", i, ov); end
    end
    tick(1'b1, OPCODE_LH, 2'd2, 32'hF00F_0000, 32'h0, 33'h0_FFFF_F00F, 1'b1, acc, ov, xfer, obs);
    tick(1'b0, 6'h0, 2'd0, 32'h0, 32'h0, 33'h0, 1'b1, acc, ov, xfer, obs);
    checks++;
    if (!xfer || expq.size() == 0) begin errors++; $display("FAIL rstmid_recover: got xfer=%b, expected 1", xfer); end
    else begin
      exp = expq.pop_front();
      if (obs !== exp) begin errors++; $display("FAIL rstmid_recover_data: got %h, expected %h", obs, exp); end
    end
    expq.delete();
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_opcode   = 6'h0;
    in_offset   = 2'd0;
    in_mem_data = 32'h0;
    in_rt_data  = 32'h0;
    out_ready   = 1'b0;
    @(negedge clk);
    test_reset;
    test_format;
    test_back_to_back;
    test_no_bubble;
    test_random;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
